lcd_bcd_feeder: RTL and testbench

Upstream feeder for the LCD controller. Accepts binary values through a write strobe, buffers them in a small FIFO, converts each to packed BCD with a sequential shift-and-add-3 engine, and presents each result to the LCD controller with a one-cycle write pulse. Writes are gated by the controller's ready flag, so no update is lost while a transfer is in progress.

---
 rtl/lcd_bcd_feeder.sv | 132 +++++++++++++
 tb/tb_lcd_bcd_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bcd_feeder.sv
// lcd_bcd_feeder: buffers binary values in a small FIFO, converts each one to
// packed BCD with a sequential shift-and-add-3 engine, and hands the result to
// the LCD controller with a one-cycle write pulse once the controller is ready.
//
// Ports:
//   CLK, RST     clock (posedge) and synchronous active-high reset
//   IN_DATA      binary value, captured when IN_WE is sampled high
//   IN_WE        write strobe into the FIFO
//   IN_FULL      FIFO holds DEPTH entries
//   DROP         one-cycle pulse after a write was rejected because of full
//   OUT_DATA     packed BCD, most significant digit in the top nibble
//   OUT_WE       one-cycle write pulse to the LCD controller
//   OUT_READY    ready flag from the LCD controller
//   BUSY         conversion/transfer in progress or FIFO not empty
module lcd_bcd_feeder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 5,
    parameter int DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   IN_DATA,
    input  logic               IN_WE,
    output logic               IN_FULL,
    output logic               DROP,
    output logic [4*DIGIT-1:0] OUT_DATA,
    output logic               OUT_WE,
    input  logic               OUT_READY,
    output logic               BUSY
);

    localparam int BW = 4 * DIGIT;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Largest value representable in DIGIT decimal digits.
    localparam logic [63:0] MAXV = pow10(DIGIT) - 64'd1;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAIT, SEND, HOLD} state_t;
    state_t state, next_state;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [BW-1:0]    bcd, bcd_adj, bcd_next;
    logic [WIDTH-1:0] bin, head, load_val;
    logic [IW-1:0]    iter;
    logic             push, pop, full, last;

    // Write acceptance looks at the count before any same-cycle pop.
    assign full    = (count == CW'(DEPTH));
    assign push    = IN_WE && !full;
    assign pop     = (state == LOAD);
    assign IN_FULL = full;
    assign BUSY    = (state != IDLE) || (count != '0);

    assign head     = mem[rd_ptr];
    assign load_val = (64'(head) > MAXV) ? MAXV[WIDTH-1:0] : head;
    assign last     = (iter == IW'(WIDTH - 1));

    // Add 3 to every nibble >= 5 before the shift so it carries as decimal.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGIT; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    assign bcd_next = {bcd_adj[BW-2:0], bin[WIDTH-1]};

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        OUT_WE     = 1'b0;
        unique case (state)
            IDLE:  if (count != '0) next_state = LOAD;
            LOAD:  next_state = SHIFT;
            SHIFT: if (last) next_state = WAIT;
            WAIT:  if (OUT_READY) next_state = SEND;
            SEND:  begin OUT_WE = 1'b1; next_state = HOLD; end
            HOLD:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            DROP     <= 1'b0;
            OUT_DATA <= '0;
            bcd      <= '0;
            bin      <= '0;
            iter     <= '0;
        end else begin
            DROP <= IN_WE && full;
            if (push) begin
                mem[wr_ptr] <= IN_DATA;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (state == LOAD) begin
                bin  <= load_val;
                bcd  <= '0;
                iter <= '0;
            end else if (state == SHIFT) begin
                bcd  <= bcd_next;
                bin  <= bin << 1;
                iter <= iter + IW'(1);
                // Final iteration: publish the fully shifted accumulator.
                if (last) OUT_DATA <= bcd_next;
            end
        end
    end

endmodule

// File: tb/tb_lcd_bcd_feeder.sv
module tb_lcd_bcd_feeder;

    localparam int P_IDLE = 0, P_LOAD = 1, P_CONV = 2, P_WAIT = 3, P_SEND = 4, P_HOLD = 5;

    logic        CLK = 1'b0;
    logic        RST, IN_WE, OUT_READY;
    logic [15:0] IN_DATA;
    logic        IN_FULL, DROP, OUT_WE, BUSY;
    logic [19:0] OUT_DATA;

    logic        in4_we;
    logic [15:0] in4_data;
    logic        full4, drop4, we4, busy4;
    logic [15:0] out4;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          q[$];
    int          ph, cnt;
    logic [31:0] m_res, m_out;
    logic        m_drop;

    always #5 CLK = ~CLK;

    lcd_bcd_feeder #(.WIDTH(16), .DIGIT(5), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_WE(IN_WE), .IN_FULL(IN_FULL),
        .DROP(DROP), .OUT_DATA(OUT_DATA), .OUT_WE(OUT_WE), .OUT_READY(OUT_READY), .BUSY(BUSY));

    lcd_bcd_feeder #(.WIDTH(16), .DIGIT(4), .DEPTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .IN_DATA(in4_data), .IN_WE(in4_we), .IN_FULL(full4),
        .DROP(drop4), .OUT_DATA(out4), .OUT_WE(we4), .OUT_READY(1'b1), .BUSY(busy4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decimal digits via plain arithmetic, saturated to the digit count.
    function automatic logic [31:0] to_bcd(input int v, input int digits);
        int maxv, x;
        logic [31:0] r;
        maxv = 1;
        for (int i = 0; i < digits; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        x = (v > maxv) ? maxv : v;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_edge(input logic we, input int d, input logic rdy, input logic rst);
        int  n;
        bit  acc;
        if (rst) begin
            q.delete();
            ph = P_IDLE; cnt = 0; m_out = '0; m_drop = 1'b0;
        end else begin
            n      = q.size();
            acc    = we && (n < 4);
            m_drop = we && !acc;
            case (ph)
                P_IDLE: if (n > 0) ph = P_LOAD;
                P_LOAD: begin m_res = to_bcd(q.pop_front(), 5); cnt = 0; ph = P_CONV; end
                P_CONV: begin cnt++; if (cnt == 16) begin m_out = m_res; ph = P_WAIT; end end
                P_WAIT: if (rdy) ph = P_SEND;
                P_SEND: ph = P_HOLD;
                default: ph = P_IDLE;
            endcase
            if (acc) q.push_back(d);
        end
    endtask

    // One clock: drive inputs, advance, update the model, compare everything.
    task automatic cyc(input logic we, input logic [15:0] d, input logic rdy, input logic rst);
        IN_WE = we; IN_DATA = d; OUT_READY = rdy; RST = rst;
        @(posedge CLK);
        model_edge(we, int'(d), rdy, rst);
        #1;
        chk("out_we",   32'(OUT_WE),   32'(ph == P_SEND));
        chk("out_data", 32'(OUT_DATA), m_out);
        chk("drop",     32'(DROP),     32'(m_drop));
        chk("in_full",  32'(IN_FULL),  32'(q.size() == 4));
        chk("busy",     32'(BUSY),     32'(ph != P_IDLE || q.size() > 0));
    endtask

    // Idle cycles until OUT_WE is seen; n = cycles elapsed (bounded).
    task automatic run_until_we(input logic rdy, output int n);
        n = 0;
        do begin
            cyc(1'b0, 16'd0, rdy, 1'b0);
            n++;
        end while (!OUT_WE && n < 200);
    endtask

    initial begin
        int n, pulses;
        logic [19:0] got[$];
        ph = P_IDLE; cnt = 0; m_out = '0; m_drop = 1'b0; m_res = '0;
        in4_we = 1'b0; in4_data = '0;

        // Reset
        cyc(1'b0, 16'd0, 1'b1, 1'b1);
        cyc(1'b0, 16'd0, 1'b1, 1'b1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_data", 32'(OUT_DATA), 32'd0);

        // Single value, minimum latency
        cyc(1'b1, 16'd1234, 1'b1, 1'b0);
        run_until_we(1'b1, n);
        chk("lat_1234", 32'(n), 32'd19);
        chk("data_1234", 32'(OUT_DATA), 32'h01234);
        repeat (4) cyc(1'b0, 16'd0, 1'b1, 1'b0);

        // Back-to-back values, throughput
        cyc(1'b1, 16'd65535, 1'b1, 1'b0);
        cyc(1'b1, 16'd0, 1'b1, 1'b0);
        run_until_we(1'b1, n);
        chk("data_65535", 32'(OUT_DATA), 32'h65535);
        run_until_we(1'b1, n);
        chk("gap_pulses", 32'(n), 32'd21);
        chk("data_zero", 32'(OUT_DATA), 32'h00000);
        repeat (4) cyc(1'b0, 16'd0, 1'b1, 1'b0);

        // Ready held low: engine takes the first, FIFO fills, sixth dropped
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 16'(k * 10), 1'b0, 1'b0);
            chk("full_seq", 32'(IN_FULL), 32'(k >= 5));
        end
        chk("drop_6th", 32'(DROP), 32'd1);
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        chk("drop_once", 32'(DROP), 32'd0);
        repeat (30) cyc(1'b0, 16'd0, 1'b0, 1'b0);
        chk("wait_no_we", 32'(OUT_WE), 32'd0);
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            cyc(1'b0, 16'd0, 1'b1, 1'b0);
            if (OUT_WE) begin pulses++; got.push_back(OUT_DATA); end
        end
        chk("pulse_cnt", 32'(pulses), 32'd5);
        for (int k = 0; k < 5; k++)
            chk("burst_data", (k < got.size()) ? 32'(got[k]) : 32'hdead, 32'(to_bcd((k + 1) * 10, 5)));

        // Reset in the middle of a conversion
        cyc(1'b1, 16'd500, 1'b1, 1'b0);
        repeat (6) cyc(1'b0, 16'd0, 1'b1, 1'b0);
        cyc(1'b0, 16'd0, 1'b1, 1'b1);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_data", 32'(OUT_DATA), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 16'd0, 1'b1, 1'b0);
            if (OUT_WE) pulses++;
        end
        chk("rst_no_we", 32'(pulses), 32'd0);
        cyc(1'b1, 16'd42, 1'b1, 1'b0);
        run_until_we(1'b1, n);
        chk("lat_42", 32'(n), 32'd19);
        chk("data_42", 32'(OUT_DATA), 32'h00042);
        repeat (4) cyc(1'b0, 16'd0, 1'b1, 1'b0);

        // Ready pulsed once every 7 cycles with three values queued
        cyc(1'b1, 16'd7, 1'b0, 1'b0);
        cyc(1'b1, 16'd4321, 1'b0, 1'b0);
        cyc(1'b1, 16'd99, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) cyc(1'b0, 16'd0, (i % 7) == 0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(0, 99) < 30), 16'($urandom), ($urandom_range(0, 99) < 50), 1'b0);
        repeat (150) cyc(1'b0, 16'd0, 1'b1, 1'b0);

        // Four-digit instance: saturation
        for (int k = 0; k < 4; k++) begin
            logic [15:0] v, e;
            case (k)
                0: begin v = 16'd12345; e = 16'h9999; end
                1: begin v = 16'd9999;  e = 16'h9999; end
                2: begin v = 16'd10000; e = 16'h9999; end
                default: begin v = 16'd7; e = 16'h0007; end
            endcase
            in4_we = 1'b1; in4_data = v;
            cyc(1'b0, 16'd0, 1'b1, 1'b0);
            in4_we = 1'b0;
            n = 0;
            while (!we4 && n < 100) begin
                cyc(1'b0, 16'd0, 1'b1, 1'b0);
                n++;
            end
            chk("d4_lat", 32'(n), 32'd19);
            chk("d4_data", 32'(out4), 32'(e));
            repeat (3) cyc(1'b0, 16'd0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
